program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Byte-stream writer for the instruction memory that the MiniAlu fetch path reads. It receives a framed program image over a valid/ready byte interface and assembles 28-bit instruction words. It writes the words to the instruction store at consecutive addresses from 0. It holds the CPU in reset until the whole image, including its checksum, is accepted.

Parameters:
ADDR_WIDTH, 16, instruction address width; must match the fetch address width.
INSN_WIDTH, 28, instruction word width. Fixed at 28: 4 bytes per word, upper nibble of the first byte discarded.

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-low reset (0 = reset).
iStart  input  1  begin a load; honoured only in IDLE, DONE, ERROR.
iByte  input  8  stream data byte.
iByteValid  input  1  iByte valid this cycle.
oByteReady  output  1  loader can accept a byte this cycle.
oWriteEnable  output  1  one-cycle write strobe to the instruction store.
oWriteAddress  output  ADDR_WIDTH  write address.
oWriteData  output  INSN_WIDTH  instruction word.
oCpuReset  output  1  active-high reset to the CPU.
oDone  output  1  image loaded and checksum good.
oError  output  1  framing or checksum failure.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; oCpuReset=1; oDone, oError, oWriteEnable = 0; oWriteAddress, oWriteData, word counter, byte index, checksum = 0. Reset asserted mid-load aborts the load; nothing further is written.
- All outputs are registered. oByteReady is decoded from the state register only: 1 in HDR_HI, HDR_LO, WORD, CHECK; 0 in IDLE, WRITE, DONE, ERROR.
- A byte transfers on a rising edge with iByteValid=1 and oByteReady=1. The loader never drops a transfer and never takes a byte without valid.
- Frame format: count_hi, count_lo, then count × 4 instruction bytes (big-endian), then 1 checksum byte.
- Checksum = XOR of every byte from count_hi through the last instruction byte. It resets to 0 on each start.
- State transitions:
  - IDLE: iStart=1 → HDR_HI; clear oDone, oError, checksum, counters; oCpuReset stays 1.
  - HDR_HI: transfer → count[15:8].
  - HDR_LO: transfer → count[7:0].
    - count=0 → CHECK.
    - count > 2^ADDR_WIDTH → ERROR.
    - otherwise → WORD, byte index 0.
  - WORD, byte 0: bits[7:4] must be 0, else → ERROR; bits[3:0] → data[27:24].
  - WORD, bytes 1, 2, 3 → data[23:16], [15:8], [7:0]. After byte 3 → WRITE.
  - WRITE (exactly one cycle): oWriteEnable=1, oWriteAddress = word counter, oWriteData = assembled word. Word counter increments. If counter+1 = count → CHECK, else → WORD.
  - CHECK: transfer; byte = checksum → DONE, else → ERROR.
  - DONE: oDone=1, oCpuReset=0. iStart=1 → HDR_HI, oCpuReset=1, oDone=0.
  - ERROR: oError=1, oCpuReset=1. iStart=1 → HDR_HI, oError=0.
- Latency: the 4th byte of a word transfers at edge N. oWriteEnable is high between edges N and N+1, and the store samples it at edge N+1. One bubble cycle (ready=0) follows every word.
- oCpuReset falls on the same edge that enters DONE. The CPU never sees a partial image.
- iStart outside IDLE/DONE/ERROR is ignored. iByteValid while ready=0 is ignored (held by sender).
- oWriteAddress and oWriteData hold their last value outside WRITE. The word counter never wraps: the count check at HDR_LO bounds it.

Test Plan:
- Reset=0 mid-stream, then release → oCpuReset=1, oByteReady=0, oDone=0, oError=0, oWriteEnable=0, address/data 0, state IDLE.
- iStart, then bytes 00 02 | 01 02 03 04 | 00 00 00 FF | F9, valid every cycle:
  - writes addr 0 = 0x1020304, then addr 1 = 0x00000FF, each a one-cycle strobe the edge after its 4th byte;
  - ready=0 for one cycle after each word;
  - oDone=1, oCpuReset=0 after the F9 transfer.
- Same frame with checksum 0xF8 → both writes occur; oError=1, oDone=0, oCpuReset stays 1. iStart, then a good frame → oError clears, oDone=1.
- Frame 00 01 | 1A 00 00 00 (upper nibble nonzero) → ERROR after the 3rd byte; no write strobe.
- Frame 00 00 | 00 → no writes; DONE; oCpuReset=0.
- Random iByteValid gaps, plus iStart pulsed mid-frame → identical writes and final state as the back-to-back case; the mid-frame iStart has no effect.

Source files
------------

// File: rtl/program_loader.sv
// Purpose : byte-stream loader that frames, checks and writes a program image into the instruction store.
// Latency : a word is written (oWriteEnable high) the cycle after its 4th byte transfers; oCpuReset drops on the edge entering DONE.
// Backpr. : oByteReady decoded from state; low in IDLE/WRITE/DONE/ERROR, so one bubble follows every word.
//
// Ports:
//   Clock, Reset          - rising-edge clock, asynchronous active-low reset
//   iStart                - begin a load (honoured only in IDLE, DONE, ERROR)
//   iByte/iByteValid      - stream byte and its valid qualifier
//   oByteReady            - loader accepts a byte this cycle
//   oWriteEnable          - one-cycle write strobe to the instruction store
//   oWriteAddress/Data    - store address and 28-bit instruction word (hold outside WRITE)
//   oCpuReset             - active-high CPU reset, released only after a good image
//   oDone / oError        - load completed with good checksum / framing or checksum failure
//
// Frame: count_hi, count_lo, count x 4 big-endian instruction bytes, checksum byte.
// Checksum is the XOR of every byte from count_hi through the last instruction byte.

module program_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int INSN_WIDTH = 28
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [7:0]            iByte,
    input  logic                  iByteValid,
    output logic                  oByteReady,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [INSN_WIDTH-1:0] oWriteData,
    output logic                  oCpuReset,
    output logic                  oDone,
    output logic                  oError
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_WORD   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    // Largest legal word count is the full address space.
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    state_t                  state_q, state_d;
    logic [15:0]             count_q, count_d;
    logic [15:0]             word_cnt_q, word_cnt_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [7:0]              csum_q, csum_d;
    // Upper three bytes of the word being assembled; the 4th byte goes
    // straight into the write data register.
    logic [27:8]             asm_q, asm_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [INSN_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    byte_rdy;
    logic                    xfer;
    logic [15:0]             new_count;
    logic [15:0]             word_cnt_inc;
    logic                    count_too_big;

    // Ready is a pure decode of the state register, so it is glitch-free
    // and never depends on iByteValid.
    always_comb begin
        case (state_q)
            S_HDR_HI, S_HDR_LO, S_WORD, S_CHECK: byte_rdy = 1'b1;
            default:                             byte_rdy = 1'b0;
        endcase
    end

    assign xfer          = iByteValid & byte_rdy;
    assign new_count     = {count_q[15:8], iByte};
    assign word_cnt_inc  = word_cnt_q + 16'd1;
    assign count_too_big = ({17'd0, new_count} > MAX_WORDS);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        cpu_rst_d  = cpu_rst_q;
        done_d     = done_q;
        error_d    = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (iStart) begin
                    state_d    = S_HDR_HI;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_rst_d  = 1'b1;
                    csum_d     = 8'd0;
                    count_d    = 16'd0;
                    word_cnt_d = 16'd0;
                    byte_idx_d = 2'd0;
                end
            end

            S_HDR_HI: begin
                if (xfer) begin
                    count_d[15:8] = iByte;
                    csum_d        = csum_q ^ iByte;
                    state_d       = S_HDR_LO;
                end
            end

            S_HDR_LO: begin
                if (xfer) begin
                    count_d = new_count;
                    csum_d  = csum_q ^ iByte;
                    if (new_count == 16'd0) begin
                        state_d = S_CHECK;
                    end else if (count_too_big) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d    = S_WORD;
                        byte_idx_d = 2'd0;
                    end
                end
            end

            S_WORD: begin
                if (xfer) begin
                    csum_d = csum_q ^ iByte;
                    case (byte_idx_q)
                        2'd0: begin
                            // Only 28 bits per word: a set upper nibble means a corrupt frame.
                            if (iByte[7:4] != 4'd0) begin
                                state_d = S_ERROR;
                                error_d = 1'b1;
                            end else begin
                                asm_d[27:24] = iByte[3:0];
                                byte_idx_d   = 2'd1;
                            end
                        end
                        2'd1: begin
                            asm_d[23:16] = iByte;
                            byte_idx_d   = 2'd2;
                        end
                        2'd2: begin
                            asm_d[15:8] = iByte;
                            byte_idx_d  = 2'd3;
                        end
                        default: begin
                            // Strobe is registered here so it is high throughout WRITE.
                            wdata_d    = INSN_WIDTH'({asm_q[27:8], iByte});
                            waddr_d    = ADDR_WIDTH'(word_cnt_q);
                            we_d       = 1'b1;
                            byte_idx_d = 2'd0;
                            state_d    = S_WRITE;
                        end
                    endcase
                end
            end

            S_WRITE: begin
                word_cnt_d = word_cnt_inc;
                if (word_cnt_inc == count_q) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_WORD;
                end
            end

            S_CHECK: begin
                if (xfer) begin
                    if (iByte == csum_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            count_q    <= 16'd0;
            word_cnt_q <= 16'd0;
            byte_idx_q <= 2'd0;
            csum_q     <= 8'd0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign oByteReady    = byte_rdy;
    assign oWriteEnable  = we_q;
    assign oWriteAddress = waddr_q;
    assign oWriteData    = wdata_q;
    assign oCpuReset     = cpu_rst_q;
    assign oDone         = done_q;
    assign oError        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Purpose : directed checks of framing, write strobes, checksum and CPU reset release.
// Latency : bytes driven at the falling edge, transferred at the next rising edge.
// Backpr. : each byte is held until oByteReady is seen high, bounded by a cycle budget.

module tb_program_loader;

    logic        Clock;
    logic        Reset;
    logic        iStart;
    logic [7:0]  iByte;
    logic        iByteValid;
    logic        oByteReady;
    logic        oWriteEnable;
    logic [15:0] oWriteAddress;
    logic [27:0] oWriteData;
    logic        oCpuReset;
    logic        oDone;
    logic        oError;

    int errors = 0;
    int checks = 0;

    // Write log filled by the monitor, read by the stimulus process.
    int          wr_cnt = 0;
    logic [15:0] wa [0:31];
    logic [27:0] wd [0:31];

    program_loader #(.ADDR_WIDTH(16), .INSN_WIDTH(28)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStart       (iStart),
        .iByte        (iByte),
        .iByteValid   (iByteValid),
        .oByteReady   (oByteReady),
        .oWriteEnable (oWriteEnable),
        .oWriteAddress(oWriteAddress),
        .oWriteData   (oWriteData),
        .oCpuReset    (oCpuReset),
        .oDone        (oDone),
        .oError       (oError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (oWriteEnable === 1'b1) begin
            wa[wr_cnt % 32] <= oWriteAddress;
            wd[wr_cnt % 32] <= oWriteData;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        iByte      = b;
        iByteValid = 1'b1;
        while (oByteReady !== 1'b1 && guard < 20) begin
            @(negedge Clock);
            guard++;
        end
        chk("ready_wait", {31'd0, (guard < 20)}, 32'd1);
        @(posedge Clock);
        @(negedge Clock);
        iByteValid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        int gap;
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge Clock);
        send(b);
    endtask

    task automatic start_load();
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
    endtask

    int base;

    initial begin
        Reset      = 1'b0;
        iStart     = 1'b0;
        iByte      = 8'h00;
        iByteValid = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);

        // Reset asserted in the middle of a load.
        start_load();
        send(8'h00);
        send(8'h02);
        send(8'h01);
        Reset = 1'b0;
        #1;
        chk("rst_cpu_reset", {31'd0, oCpuReset}, 32'd1);
        chk("rst_ready",     {31'd0, oByteReady}, 32'd0);
        chk("rst_done",      {31'd0, oDone}, 32'd0);
        chk("rst_error",     {31'd0, oError}, 32'd0);
        chk("rst_we",        {31'd0, oWriteEnable}, 32'd0);
        chk("rst_addr",      {16'd0, oWriteAddress}, 32'd0);
        chk("rst_data",      {4'd0, oWriteData}, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        chk("post_rst_ready", {31'd0, oByteReady}, 32'd0);
        chk("post_rst_writes", wr_cnt, 32'd0);

        // Good two-word frame, valid every cycle.
        base = wr_cnt;
        start_load();
        chk("start_ready", {31'd0, oByteReady}, 32'd1);
        send(8'h00); send(8'h02);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("w0_we",    {31'd0, oWriteEnable}, 32'd1);
        chk("w0_addr",  {16'd0, oWriteAddress}, 32'd0);
        chk("w0_data",  {4'd0, oWriteData}, 32'h0102_0304);
        chk("w0_bubble", {31'd0, oByteReady}, 32'd0);
        @(negedge Clock);
        chk("w0_we_low",  {31'd0, oWriteEnable}, 32'd0);
        chk("w0_ready_back", {31'd0, oByteReady}, 32'd1);
        chk("w0_hold_data", {4'd0, oWriteData}, 32'h0102_0304);
        send(8'h00); send(8'h00); send(8'h00); send(8'hFF);
        chk("w1_we",    {31'd0, oWriteEnable}, 32'd1);
        chk("w1_addr",  {16'd0, oWriteAddress}, 32'd1);
        chk("w1_data",  {4'd0, oWriteData}, 32'h0000_00FF);
        chk("w1_bubble", {31'd0, oByteReady}, 32'd0);
        chk("pre_ck_cpu_reset", {31'd0, oCpuReset}, 32'd1);
        send(8'hF9);
        chk("good_done",   {31'd0, oDone}, 32'd1);
        chk("good_cpu",    {31'd0, oCpuReset}, 32'd0);
        chk("good_error",  {31'd0, oError}, 32'd0);
        chk("good_ready",  {31'd0, oByteReady}, 32'd0);
        chk("good_writes", wr_cnt - base, 32'd2);

        // Same frame with a wrong checksum.
        base = wr_cnt;
        start_load();
        chk("restart_cpu", {31'd0, oCpuReset}, 32'd1);
        chk("restart_done", {31'd0, oDone}, 32'd0);
        send(8'h00); send(8'h02);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h00); send(8'h00); send(8'h00); send(8'hFF);
        send(8'hF8);
        chk("bad_ck_error",  {31'd0, oError}, 32'd1);
        chk("bad_ck_done",   {31'd0, oDone}, 32'd0);
        chk("bad_ck_cpu",    {31'd0, oCpuReset}, 32'd1);
        chk("bad_ck_writes", wr_cnt - base, 32'd2);
        chk("bad_ck_w0", {4'd0, wd[base % 32]}, 32'h0102_0304);
        chk("bad_ck_w1", {4'd0, wd[(base + 1) % 32]}, 32'h0000_00FF);

        // Recover from ERROR with a good frame.
        base = wr_cnt;
        start_load();
        chk("err_clear", {31'd0, oError}, 32'd0);
        send(8'h00); send(8'h02);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h00); send(8'h00); send(8'h00); send(8'hFF);
        send(8'hF9);
        chk("recover_done",  {31'd0, oDone}, 32'd1);
        chk("recover_error", {31'd0, oError}, 32'd0);
        chk("recover_cpu",   {31'd0, oCpuReset}, 32'd0);

        // Upper nibble set on the first instruction byte.
        base = wr_cnt;
        start_load();
        send(8'h00); send(8'h01); send(8'h1A);
        chk("nib_error",  {31'd0, oError}, 32'd1);
        chk("nib_ready",  {31'd0, oByteReady}, 32'd0);
        chk("nib_cpu",    {31'd0, oCpuReset}, 32'd1);
        repeat (3) @(negedge Clock);
        chk("nib_writes", wr_cnt - base, 32'd0);

        // Empty image.
        base = wr_cnt;
        start_load();
        send(8'h00); send(8'h00); send(8'h00);
        chk("empty_done",   {31'd0, oDone}, 32'd1);
        chk("empty_cpu",    {31'd0, oCpuReset}, 32'd0);
        chk("empty_writes", wr_cnt - base, 32'd0);

        // Random valid gaps, with iStart pulsed mid-frame.
        base = wr_cnt;
        start_load();
        send_gap(8'h00); send_gap(8'h02);
        send_gap(8'h01); send_gap(8'h02);
        start_load();
        send_gap(8'h03); send_gap(8'h04);
        send_gap(8'h00); send_gap(8'h00); send_gap(8'h00); send_gap(8'hFF);
        send_gap(8'hF9);
        chk("gap_writes", wr_cnt - base, 32'd2);
        chk("gap_a0", {16'd0, wa[base % 32]}, 32'd0);
        chk("gap_d0", {4'd0, wd[base % 32]}, 32'h0102_0304);
        chk("gap_a1", {16'd0, wa[(base + 1) % 32]}, 32'd1);
        chk("gap_d1", {4'd0, wd[(base + 1) % 32]}, 32'h0000_00FF);
        chk("gap_done",  {31'd0, oDone}, 32'd1);
        chk("gap_cpu",   {31'd0, oCpuReset}, 32'd0);
        chk("gap_error", {31'd0, oError}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
